// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and helpers for the forwarding/hazard controller
package fwd_pkg;

    typedef enum logic {FWD_RUN, FWD_STALL} fwd_state_t;

    localparam int FWD_SEL_REGFILE = 0;

    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side operand/writer bus for fwd_hazard_ctrl
interface fwd_hazard_ctrl_if
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = sel_w(NUM_STAGES),
    parameter int CNT_W      = 32
) ();

    logic [NUM_SRC*REG_AW-1:0]    src_addr;
    logic [NUM_SRC-1:0]           src_re;
    logic [NUM_STAGES*REG_AW-1:0] wr_addr;
    logic [NUM_STAGES-1:0]        wr_en;
    logic [NUM_STAGES-1:0]        wr_rdy;
    logic                         flush;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
    logic                         stall;
    logic                         stall_timeout;
    logic [NUM_SRC*CNT_W-1:0]     stat_fwd;
    logic [CNT_W-1:0]             stat_stall;

    modport master (
        output src_addr, src_re, wr_addr, wr_en, wr_rdy, flush,
        input  fwd_sel, stall, stall_timeout, stat_fwd, stat_stall
    );

    modport slave (
        input  src_addr, src_re, wr_addr, wr_en, wr_rdy, flush,
        output fwd_sel, stall, stall_timeout, stat_fwd, stat_stall
    );

endinterface

// File: rtl/fwd_port_match.sv
// rtl/fwd_port_match.sv - resolves one source operand against all in-flight writers
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = sel_w(NUM_STAGES)
) (
    input  logic [REG_AW-1:0]            addr,
    input  logic                         re,
    input  logic [NUM_STAGES*REG_AW-1:0] wr_addr,
    input  logic [NUM_STAGES-1:0]        wr_en,
    input  logic [NUM_STAGES-1:0]        wr_rdy,
    output logic [SEL_W-1:0]             sel,
    output logic                         hazard
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel    = SEL_W'(FWD_SEL_REGFILE);
        hazard = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (re && (addr != '0) && wr_en[k] && (wr_addr[k*REG_AW +: REG_AW] == addr)) begin
                sel    = SEL_W'(k + 1);
                hazard = ~wr_rdy[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding selects, stall FSM and watchdog; FWD_STATS_EN adds counters
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = sel_w(NUM_STAGES),
    parameter int MAX_STALL  = 16,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    localparam int CW = $clog2(MAX_STALL + 1);

    logic [NUM_SRC*SEL_W-1:0] sel_vec;
    logic [NUM_SRC-1:0]       hazard;
    logic                     stall;
    fwd_state_t               state_q, state_d;
    logic [CW-1:0]            stall_cnt, cnt_d;
    logic                     timeout_q, timeout_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_port_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_match (
            .addr    (bus.src_addr[i*REG_AW +: REG_AW]),
            .re      (bus.src_re[i]),
            .wr_addr (bus.wr_addr),
            .wr_en   (bus.wr_en),
            .wr_rdy  (bus.wr_rdy),
            .sel     (sel_vec[i*SEL_W +: SEL_W]),
            .hazard  (hazard[i])
        );
    end

    // Flush overrides any hazard so the cancelled instruction is not held.
    assign stall             = (|hazard) & ~bus.flush;
    assign bus.fwd_sel       = sel_vec;
    assign bus.stall         = stall;
    assign bus.stall_timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        case (state_q)
            FWD_RUN:   if (stall) state_d = FWD_STALL;
            FWD_STALL: if (!stall || bus.flush) state_d = FWD_RUN;
        endcase
        if (state_d == FWD_STALL) begin
            cnt_d = (stall_cnt == CW'(MAX_STALL)) ? stall_cnt : stall_cnt + CW'(1);
        end
        if (stall && (cnt_d == CW'(MAX_STALL))) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FWD_RUN;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_cnt <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_stat;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
        logic [CNT_W-1:0] fwd_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fwd_cnt <= '0;
            end else if ((sel_vec[i*SEL_W +: SEL_W] != '0) && !stall && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
        assign bus.stat_fwd[i*CNT_W +: CNT_W] = fwd_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_stat <= '0;
        end else if (stall && (stall_stat != '1)) begin
            stall_stat <= stall_stat + CNT_W'(1);
        end
    end
    assign bus.stat_stall = stall_stat;
`else
    assign bus.stat_fwd   = '0;
    assign bus.stat_stall = '0;
`endif

endmodule
